sha_round_state: RTL and testbench
==================================

Name: sha_round_state

Overview:
- Parametrised working-variable bank for the SHA-2 compression loop. Holds all eight working words a..h.
- Loads them from the intermediate hash, then applies one round update per cycle using externally computed T1/T2 for ROUNDS cycles.
- Finishes with a feed-forward add that produces the next intermediate hash.
- Sits between the message-schedule/T1-T2 datapath and the digest output. WORD_W selects SHA-256 (32) or SHA-512 (64).

Parameters:
- WORD_W, 32, width of each working word and of T1/T2.
- ROUNDS, 64, round updates per block (80 for SHA-512).
- CNT_W, $clog2(ROUNDS), round counter width. Derived localparam; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a block; sampled in IDLE only.
- abort  in  1  synchronous abandon; return to IDLE without done.
- h_in  in  8*WORD_W  intermediate hash H0..H7; H0 occupies the MS word.
- t1  in  WORD_W  round T1, computed combinationally from state_out and round_idx.
- t2  in  WORD_W  round T2, computed the same way.
- state_out  out  8*WORD_W  current a..h; a occupies the MS word.
- round_idx  out  CNT_W  index of the round being applied (drives K/W lookup).
- busy  out  1  high in ROUND and FINAL.
- done  out  1  one-cycle pulse when digest_out is updated.
- digest_out  out  8*WORD_W  registered feed-forward result; held until the next done.

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE, and state_out, the saved hash, round_idx, busy, done and digest_out all clear to 0.
- States are IDLE, ROUND and FINAL.
- IDLE:
  - When start=1 and abort=0: state words are loaded from h_in (a..h = H0..H7), h_in is copied to an internal hsave, round_idx=0, next state=ROUND.
  - start=1 together with abort=1 is ignored.
- ROUND, each edge:
  - h<=g, g<=f, f<=e, e<=d+t1, d<=c, c<=b, b<=a, a<=t1+t2.
  - All additions are modulo 2^WORD_W; carries are dropped.
  - round_idx increments by 1.
  - If round_idx==ROUNDS-1 on this edge, the update is applied, round_idx wraps to 0 and next state=FINAL.
- FINAL, one edge:
  - digest_out word i <= hsave word i + state word i (mod 2^WORD_W).
  - done<=1 for exactly one cycle, next state=IDLE.
  - state_out keeps its post-round values.
- Latency: if start is accepted at edge N, round k is applied at edge N+1+k, and digest/done are registered at edge N+ROUNDS+1.
- start while busy=1 is ignored; no queuing.
- abort in ROUND or FINAL wins over every other action:
  - Next state=IDLE, round_idx=0, no done.
  - digest_out and state_out keep their values.
- abort in IDLE has no effect.
- done is 0 in every cycle except the one following the FINAL edge.
- Back-to-back blocks: start may be asserted in the cycle done is high (FSM is already IDLE), and it is accepted.
- Reset mid-block returns every register to its reset value immediately.

Decomposition:
- Shared package sha_pkg holds:
  - the FSM state enum (IDLE/ROUND/FINAL);
  - NUM_WORDS=8;
  - word-select index constants A..H;
  - SHA-256 and SHA-512 initial-hash constants, for benches and top-level muxing.
- One sub-module, sha_feedforward_add: eight parallel WORD_W modular adders, hsave + state -> digest. It is purely combinational; its result is registered in this block.

Test Plan:
- Load and first round:
  - Stimulus: reset, h_in = SHA-256 IV (6a09e667 … 5be0cd19), start 1 cycle, t1=00000001, t2=00000002.
  - Required: after first round edge, a=00000003, b=6a09e667, e=a54ff53b, h=1f83d9ab, round_idx=1.
- Full block ("abc"):
  - Stimulus: bench reference model drives t1/t2 from state_out/round_idx.
  - Required: done exactly 65 edges after start is accepted; digest_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Wrap-around:
  - Stimulus: h_in all ffffffff, t1=t2=ffffffff for all rounds.
  - Required: a = fffffffe after every round; no X; digest words are computed mod 2^32.
- Abort at round 30:
  - Required: busy drops next cycle, no done pulse, round_idx=0.
  - Then a new start completes normally with the correct digest.
- start during busy and back-to-back:
  - Required: start asserted at round 10 is ignored (done timing unchanged).
  - start asserted in the done cycle is accepted, giving a second done 65 cycles later.
- WORD_W=64, ROUNDS=80:
  - Stimulus: SHA-512 "abc".
  - Required: done after 81 edges; digest begins ddaf35a193617aba.
  - Also: rst_n pulsed mid-block clears all outputs asynchronously.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-2 round-state block: FSM encoding, word
// positions inside the a..h bank, and the standard initial hash values.
package sha_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } sha_state_t;

    localparam int NUM_WORDS = 8;

    // Position of each working word; word 0 (a) sits in the most significant slot.
    localparam int WORD_A = 0;
    localparam int WORD_B = 1;
    localparam int WORD_C = 2;
    localparam int WORD_D = 3;
    localparam int WORD_E = 4;
    localparam int WORD_F = 5;
    localparam int WORD_G = 6;
    localparam int WORD_H = 7;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [511:0] SHA512_IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

endpackage

// File: rtl/sha_feedforward_add.sv
// Combinational feed-forward: eight independent modular adds of the saved
// hash and the final working words.
module sha_feedforward_add
    import sha_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [NUM_WORDS*WORD_W-1:0] hsave,
    input  logic [NUM_WORDS*WORD_W-1:0] work,
    output logic [NUM_WORDS*WORD_W-1:0] digest
);

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_add
            assign digest[gi*WORD_W +: WORD_W] = hsave[gi*WORD_W +: WORD_W] + work[gi*WORD_W +: WORD_W];
        end
    endgenerate

endmodule

// File: rtl/sha_round_state.sv
// SHA-2 working-variable bank: loads a..h from the intermediate hash, applies
// one externally computed round per cycle, then registers the feed-forward sum.
module sha_round_state
    import sha_pkg::*;
#(
    parameter  int WORD_W = 32,
    parameter  int ROUNDS = 64,
    localparam int CNT_W  = $clog2(ROUNDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_WORDS*WORD_W-1:0] h_in,
    input  logic [WORD_W-1:0]           t1,
    input  logic [WORD_W-1:0]           t2,
    output logic [NUM_WORDS*WORD_W-1:0] state_out,
    output logic [CNT_W-1:0]            round_idx,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_WORDS*WORD_W-1:0] digest_out
);

    localparam int               VEC_W    = NUM_WORDS * WORD_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

    sha_state_t        state_reg, state_next;
    logic [VEC_W-1:0]  work_reg, work_next;
    logic [VEC_W-1:0]  hsave_reg;
    logic [VEC_W-1:0]  digest_reg, digest_sum;
    logic [CNT_W-1:0]  round_idx_reg;
    logic              done_reg;
    logic              load_en, round_en, final_en, clear_idx, last_round;

    function automatic logic [WORD_W-1:0] wsel(input logic [VEC_W-1:0] v, input int idx);
        return v[(NUM_WORDS-1-idx)*WORD_W +: WORD_W];
    endfunction

    assign last_round = (round_idx_reg == LAST_IDX);

    // New a and e take the T1/T2 sums; every other word shifts down one place.
    assign work_next = {t1 + t2,
                        wsel(work_reg, WORD_A), wsel(work_reg, WORD_B), wsel(work_reg, WORD_C),
                        wsel(work_reg, WORD_D) + t1,
                        wsel(work_reg, WORD_E), wsel(work_reg, WORD_F), wsel(work_reg, WORD_G)};

    sha_feedforward_add #(.WORD_W(WORD_W)) u_ff (
        .hsave  (hsave_reg),
        .work   (work_reg),
        .digest (digest_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (start && !abort) state_next = ST_ROUND;
            ST_ROUND: begin
                if (abort)           state_next = ST_IDLE;
                else if (last_round) state_next = ST_FINAL;
            end
            ST_FINAL: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // abort outranks everything once a block is in flight
    always_comb begin
        load_en   = (state_reg == ST_IDLE) && start && !abort;
        round_en  = (state_reg == ST_ROUND) && !abort;
        final_en  = (state_reg == ST_FINAL) && !abort;
        clear_idx = (state_reg != ST_IDLE) && abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg      <= '0;
            hsave_reg     <= '0;
            digest_reg    <= '0;
            round_idx_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= final_en;
            if (load_en) begin
                work_reg      <= h_in;
                hsave_reg     <= h_in;
                round_idx_reg <= '0;
            end else if (round_en) begin
                work_reg      <= work_next;
                round_idx_reg <= last_round ? '0 : round_idx_reg + CNT_W'(1);
            end else if (clear_idx) begin
                round_idx_reg <= '0;
            end
            if (final_en) begin
                digest_reg <= digest_sum;
            end
        end
    end

    assign state_out  = work_reg;
    assign round_idx  = round_idx_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;
    assign digest_out = digest_reg;

endmodule

// File: tb/tb_sha_round_state.sv
// Scoreboard bench for sha_round_state: a SHA-256 and a SHA-512 instance are
// fed T1/T2 from a behavioural SHA-2 model; digests are checked on done.
module tb_sha_round_state;
    import sha_pkg::*;

    typedef logic [63:0] u64;
    typedef struct {
        logic [511:0] dg;
        int unsigned  cyc;
    } exp_t;

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start32, abort32, busy32, done32;
    logic [255:0] h32, so32, dg32;
    logic [31:0]  t1_32, t2_32;
    logic [5:0]   ri32;
    logic         start64, abort64, busy64, done64;
    logic [511:0] h64, so64, dg64;
    logic [63:0]  t1_64, t2_64;
    logic [6:0]   ri64;

    sha_round_state #(.WORD_W(32), .ROUNDS(64)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .abort(abort32), .h_in(h32),
        .t1(t1_32), .t2(t2_32), .state_out(so32), .round_idx(ri32), .busy(busy32),
        .done(done32), .digest_out(dg32)
    );

    sha_round_state #(.WORD_W(64), .ROUNDS(80)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .abort(abort64), .h_in(h64),
        .t1(t1_64), .t2(t2_64), .state_out(so64), .round_idx(ri64), .busy(busy64),
        .done(done64), .digest_out(dg64)
    );

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    exp_t        q32[$], q64[$];
    exp_t        mon_e;
    bit          mode_sha32, mode_sha64;
    u64          ct1, ct2;
    u64          sched32 [80];
    u64          sched64 [80];
    logic [511:0] last_exp32;
    logic [127:0] tp32, tp64;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural SHA-2 model ----------------
    function automatic u64 msk(input bit w64, input u64 x);
        return w64 ? x : {32'b0, x[31:0]};
    endfunction

    function automatic u64 rotr(input bit w64, input u64 x, input int n);
        logic [31:0] y;
        y = x[31:0];
        if (w64) return (x >> n) | (x << (64 - n));
        return {32'b0, (y >> n) | (y << (32 - n))};
    endfunction

    function automatic u64 bsig0(input bit w64, input u64 x);
        return w64 ? rotr(1, x, 28) ^ rotr(1, x, 34) ^ rotr(1, x, 39) : rotr(0, x, 2) ^ rotr(0, x, 13) ^ rotr(0, x, 22);
    endfunction

    function automatic u64 bsig1(input bit w64, input u64 x);
        return w64 ? rotr(1, x, 14) ^ rotr(1, x, 18) ^ rotr(1, x, 41) : rotr(0, x, 6) ^ rotr(0, x, 11) ^ rotr(0, x, 25);
    endfunction

    function automatic u64 ssig0(input bit w64, input u64 x);
        return w64 ? rotr(1, x, 1) ^ rotr(1, x, 8) ^ (x >> 7) : rotr(0, x, 7) ^ rotr(0, x, 18) ^ (x >> 3);
    endfunction

    function automatic u64 ssig1(input bit w64, input u64 x);
        return w64 ? rotr(1, x, 19) ^ rotr(1, x, 61) ^ (x >> 6) : rotr(0, x, 17) ^ rotr(0, x, 19) ^ (x >> 10);
    endfunction

    function automatic void calc_t(input bit w64, input u64 v[8], input u64 k, input u64 w, output u64 t1, output u64 t2);
        u64 ch, mj;
        ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
        mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
        t1 = msk(w64, v[7] + bsig1(w64, v[4]) + ch + k + w);
        t2 = msk(w64, bsig0(w64, v[0]) + mj);
    endfunction

    function automatic void expand(input bit w64, input u64 blk[16], output u64 ws[80]);
        for (int i = 0; i < 80; i++) begin
            if (i < 16) ws[i] = msk(w64, blk[i]);
            else ws[i] = msk(w64, ssig1(w64, ws[i-2]) + ws[i-7] + ssig0(w64, ws[i-15]) + ws[i-16]);
        end
    endfunction

    function automatic logic [511:0] pack(input bit w64, input u64 v[8]);
        logic [511:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (w64) p[(7-i)*64 +: 64] = v[i];
            else     p[(7-i)*32 +: 32] = v[i][31:0];
        end
        return p;
    endfunction

    function automatic void unpack(input bit w64, input logic [511:0] p, output u64 v[8]);
        for (int i = 0; i < 8; i++) begin
            if (w64) v[i] = p[(7-i)*64 +: 64];
            else     v[i] = {32'b0, p[(7-i)*32 +: 32]};
        end
    endfunction

    // Working state after nr rounds, plus the feed-forward digest of that state.
    function automatic void ref_model(input bit w64, input bit sha, input u64 h[8], input u64 ws[80],
                                      input int nr, input u64 c1, input u64 c2,
                                      output u64 st[8], output u64 dg[8]);
        u64 a1, a2, k;
        st = h;
        for (int r = 0; r < nr; r++) begin
            if (w64) k = K512[r];
            else     k = {32'b0, K256[r]};
            if (sha) calc_t(w64, st, k, ws[r], a1, a2);
            else begin a1 = msk(w64, c1); a2 = msk(w64, c2); end
            for (int j = 7; j > 0; j--) st[j] = st[j-1];
            st[4] = msk(w64, st[4] + a1);
            st[0] = msk(w64, a1 + a2);
        end
        for (int i = 0; i < 8; i++) dg[i] = msk(w64, h[i] + st[i]);
    endfunction

    // T1/T2 datapath seen by the DUTs, fed from their live state and round index
    function automatic logic [127:0] drive_t(input bit w64, input bit sha, input logic [511:0] so,
                                             input u64 k, input u64 w, input u64 c1, input u64 c2);
        u64 v[8];
        u64 a1, a2;
        if (!sha) return {msk(w64, c1), msk(w64, c2)};
        unpack(w64, so, v);
        calc_t(w64, v, k, w, a1, a2);
        return {a1, a2};
    endfunction

    assign tp32  = drive_t(1'b0, mode_sha32, {256'b0, so32}, {32'b0, K256[ri32]}, sched32[ri32], ct1, ct2);
    assign tp64  = drive_t(1'b1, mode_sha64, so64, K512[ri64], sched64[ri64], ct1, ct2);
    assign t1_32 = tp32[95:64];
    assign t2_32 = tp32[31:0];
    assign t1_64 = tp64[127:64];
    assign t2_64 = tp64[63:0];

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic void rand_block(input bit w64, output u64 blk[16]);
        for (int i = 0; i < 16; i++) blk[i] = msk(w64, {$urandom, $urandom});
    endfunction

    function automatic logic [511:0] rand_h(input bit w64);
        u64 v[8];
        for (int i = 0; i < 8; i++) v[i] = msk(w64, {$urandom, $urandom});
        return pack(w64, v);
    endfunction

    // Called at a negedge with the DUT idle; start is held for one edge.
    task automatic issue(input bit w64, input logic [511:0] h, input bit sha, input u64 ws[80],
                         input u64 c1, input u64 c2, input bit push);
        u64   hv[8], st[8], dg[8];
        exp_t e;
        unpack(w64, h, hv);
        ref_model(w64, sha, hv, ws, w64 ? 80 : 64, c1, c2, st, dg);
        ct1 = c1;
        ct2 = c2;
        if (w64) begin h64 = h; mode_sha64 = sha; sched64 = ws; start64 = 1'b1; end
        else     begin h32 = h[255:0]; mode_sha32 = sha; sched32 = ws; start32 = 1'b1; end
        if (push) begin
            e.dg  = pack(w64, dg);
            e.cyc = cyc + (w64 ? 80 : 64) + 2;
            if (w64) q64.push_back(e);
            else begin q32.push_back(e); last_exp32 = e.dg; end
        end
        @(negedge clk);
        start32 = 1'b0;
        start64 = 1'b0;
    endtask

    task automatic wait_done(input bit w64, input int limit);
        int n = 0;
        while (!(w64 ? done64 : done32) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(w64 ? done64 : done32)) begin
            failures++;
            $display("FAIL done_timeout%0d actual=no_done required=done_within_%0d", w64 ? 64 : 32, limit);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            checks++;
            if (q32.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done32 actual=%h required=no_done", dg32);
            end else begin
                mon_e = q32.pop_front();
                if (dg32 !== mon_e.dg[255:0] || cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL digest32 actual=%h@%0d required=%h@%0d", dg32, cyc, mon_e.dg[255:0], mon_e.cyc);
                end else
                    $display("txn sha256 cyc=%0d digest=%h", cyc, dg32);
            end
        end
        if (done64 === 1'b1) begin
            checks++;
            if (q64.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done64 actual=%h required=no_done", dg64);
            end else begin
                mon_e = q64.pop_front();
                if (dg64 !== mon_e.dg || cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL digest64 actual=%h@%0d required=%h@%0d", dg64, cyc, mon_e.dg, mon_e.cyc);
                end else
                    $display("txn sha512 cyc=%0d digest=%h", cyc, dg64);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        u64 blk[16];
        u64 ws[80];
        u64 zero_ws[80];
        u64 hv[8], st[8], dg[8];
        logic [511:0] h;
        int n;

        for (int i = 0; i < 80; i++) zero_ws[i] = '0;
        sched32 = zero_ws;
        sched64 = zero_ws;
        mode_sha32 = 1'b0; mode_sha64 = 1'b0; ct1 = '0; ct2 = '0;
        start32 = 0; abort32 = 0; start64 = 0; abort64 = 0;
        h32 = '0; h64 = '0; last_exp32 = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state32", {256'b0, so32}, '0);
        chk("rst_digest32", {256'b0, dg32}, '0);
        chk("rst_idx32", {506'b0, ri32}, '0);
        chk("rst_busy_done32", {510'b0, busy32, done32}, '0);
        chk("rst_state64", so64, '0);
        chk("rst_digest64", dg64, '0);
        chk("rst_idx_busy_done64", {503'b0, ri64, busy64, done64}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // load and first round with constant T1/T2
        issue(0, {256'b0, SHA256_IV}, 0, zero_ws, 64'd1, 64'd2, 1);
        @(negedge clk);
        chk("first_a", {480'b0, so32[255:224]}, 512'h00000003);
        chk("first_b", {480'b0, so32[223:192]}, 512'h6a09e667);
        chk("first_e", {480'b0, so32[127:96]}, 512'ha54ff53b);
        chk("first_h", {480'b0, so32[31:0]}, 512'h1f83d9ab);
        chk("first_idx", {506'b0, ri32}, 512'd1);
        chk("first_busy", {511'b0, busy32}, 512'd1);
        wait_done(0, 100);
        @(negedge clk);

        // SHA-256 "abc"
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 64'h61626380; blk[15] = 64'h18;
        expand(0, blk, ws);
        issue(0, {256'b0, SHA256_IV}, 1, ws, 0, 0, 1);
        wait_done(0, 100);
        chk("abc256", {256'b0, dg32},
            {256'b0, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad});
        @(negedge clk);

        // wrap-around: all ones everywhere
        issue(0, {256'b0, {256{1'b1}}}, 0, zero_ws, 64'hffffffff, 64'hffffffff, 1);
        for (int r = 0; r < 64; r++) begin
            @(negedge clk);
            chk("wrap_a", {480'b0, so32[255:224]}, 512'hfffffffe);
            chk("wrap_no_x", {511'b0, $isunknown(so32)}, '0);
        end
        wait_done(0, 10);
        @(negedge clk);

        // random blocks from random intermediate hashes
        for (int t = 0; t < 3; t++) begin
            rand_block(0, blk);
            expand(0, blk, ws);
            issue(0, rand_h(0), 1, ws, 0, 0, 1);
            wait_done(0, 100);
            @(negedge clk);
        end

        // abort at round 30
        rand_block(0, blk);
        expand(0, blk, ws);
        h = rand_h(0);
        issue(0, h, 1, ws, 0, 0, 0);
        n = 0;
        while (ri32 != 6'd30 && n < 100) begin @(negedge clk); n++; end
        chk("abort_reach30", {506'b0, ri32}, 512'd30);
        abort32 = 1'b1;
        @(negedge clk);
        abort32 = 1'b0;
        unpack(0, h, hv);
        ref_model(0, 1, hv, ws, 30, 0, 0, st, dg);
        chk("abort_busy_done", {510'b0, busy32, done32}, '0);
        chk("abort_idx", {506'b0, ri32}, '0);
        chk("abort_state_held", {256'b0, so32}, pack(0, st));
        chk("abort_digest_held", {256'b0, dg32}, last_exp32);
        repeat (70) @(negedge clk);
        chk("abort_stays_idle", {511'b0, busy32}, '0);
        rand_block(0, blk);
        expand(0, blk, ws);
        issue(0, rand_h(0), 1, ws, 0, 0, 1);
        wait_done(0, 100);
        @(negedge clk);

        // start during busy is ignored; start in the done cycle is accepted
        rand_block(0, blk);
        expand(0, blk, ws);
        issue(0, rand_h(0), 1, ws, 0, 0, 1);
        n = 0;
        while (ri32 != 6'd10 && n < 100) begin @(negedge clk); n++; end
        h32 = rand_h(0);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        wait_done(0, 100);
        rand_block(0, blk);
        expand(0, blk, ws);
        issue(0, rand_h(0), 1, ws, 0, 0, 1);
        wait_done(0, 100);
        @(negedge clk);

        // SHA-512 "abc"
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 64'h6162638000000000; blk[15] = 64'h18;
        expand(1, blk, ws);
        issue(1, SHA512_IV, 1, ws, 0, 0, 1);
        wait_done(1, 120);
        chk("abc512", dg64, {64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
                             64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f});
        @(negedge clk);

        rand_block(1, blk);
        expand(1, blk, ws);
        issue(1, rand_h(1), 1, ws, 0, 0, 1);
        wait_done(1, 120);
        @(negedge clk);

        // asynchronous reset in the middle of a block
        rand_block(1, blk);
        expand(1, blk, ws);
        issue(1, rand_h(1), 1, ws, 0, 0, 1);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state64", so64, '0);
        chk("midrst_digest64", dg64, '0);
        chk("midrst_idx_busy_done64", {503'b0, ri64, busy64, done64}, '0);
        void'(q64.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_block(1, blk);
        expand(1, blk, ws);
        issue(1, rand_h(1), 1, ws, 0, 0, 1);
        wait_done(1, 120);
        repeat (3) @(negedge clk);

        chk("queues_drained", {480'b0, 16'(q32.size()), 16'(q64.size())}, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
